// File: rtl/frame_sig_capture.sv
// Per-frame CRC-32 / pixel / line signature of the SDL pixel stream, latched once per frame.
// Optional FRAME_SIG_CMP_EN adds an expected-CRC compare with per-frame and sticky mismatch flags.
module frame_sig_capture #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600
) (
    input  logic        pixel_clk,
    input  logic        sim_rst,
    input  logic [10:0] sdl_sx,
    input  logic [9:0]  sdl_sy,
    input  logic        sdl_de,
    input  logic [7:0]  sdl_r,
    input  logic [7:0]  sdl_g,
    input  logic [7:0]  sdl_b,
`ifdef FRAME_SIG_CMP_EN
    input  logic [31:0] exp_crc,
    output logic        sig_mismatch,
    output logic        sig_mismatch_any,
`endif
    output logic [31:0] sig_crc,
    output logic [19:0] sig_pix_cnt,
    output logic [9:0]  sig_line_cnt,
    output logic        sig_err,
    output logic        sig_valid,
    output logic [15:0] frame_cnt
);

    localparam logic [0:0]  WAIT_SOF = 1'b0;
    localparam logic [0:0]  ACTIVE   = 1'b1;
    localparam logic [31:0] POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [19:0] PIX_MAX  = 20'hFFFFF;
    localparam logic [9:0]  LINE_MAX = 10'h3FF;
    localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [11:0] H_LIM    = 12'(H_ACTIVE);
    localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
    // Expected position after the SOF pixel (a one-pixel line wraps straight to the next row)
    localparam logic [10:0] X_INIT   = (H_ACTIVE == 1) ? 11'd0 : 11'd1;
    localparam logic [9:0]  Y_INIT   = (H_ACTIVE == 1) ? 10'd1 : 10'd0;

    function automatic logic [31:0] crc_pixel(input logic [31:0] crc_in, input logic [23:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 3; i++) begin
            c = c ^ {24'd0, data[23-8*i -: 8]};
            for (int j = 0; j < 8; j++) begin
                c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
            end
        end
        return c;
    endfunction

    logic [0:0]  state_reg, state_next;
    logic [31:0] crc_reg, crc_next;
    logic [19:0] pix_reg, pix_next;
    logic [9:0]  line_reg, line_next;
    logic [10:0] exp_x_reg, exp_x_next;
    logic [9:0]  exp_y_reg, exp_y_next;
    logic        err_reg, err_next;

    logic        latch;
    logic [31:0] latch_crc;
    logic [19:0] latch_pix;
    logic [9:0]  latch_line;
    logic        latch_err;

    logic        is_sof, is_eof, line_start, geom_bad;
    logic [31:0] crc_upd, crc_sof;
    logic [19:0] pix_acc;
    logic [9:0]  line_acc;
    logic        err_acc;

    assign is_sof     = sdl_de && (sdl_sx == 11'd0) && (sdl_sy == 10'd0);
    assign is_eof     = sdl_de && (sdl_sx == X_LAST) && (sdl_sy == Y_LAST);
    assign crc_upd    = crc_pixel(crc_reg, {sdl_r, sdl_g, sdl_b});
    assign crc_sof    = crc_pixel(CRC_INIT, {sdl_r, sdl_g, sdl_b});
    assign line_start = (exp_x_reg == 11'd0);
    assign geom_bad   = (sdl_sx != exp_x_reg) || (sdl_sy != exp_y_reg) ||
                        ({1'b0, sdl_sx} >= H_LIM) || ({1'b0, sdl_sy} >= V_LIM);
    assign pix_acc    = (pix_reg == PIX_MAX) ? pix_reg : pix_reg + 20'd1;
    assign line_acc   = (line_start && line_reg != LINE_MAX) ? line_reg + 10'd1 : line_reg;
    assign err_acc    = err_reg || geom_bad || (pix_reg == PIX_MAX) ||
                        (line_start && line_reg == LINE_MAX);

    always_comb begin
        state_next = state_reg;
        crc_next   = crc_reg;
        pix_next   = pix_reg;
        line_next  = line_reg;
        exp_x_next = exp_x_reg;
        exp_y_next = exp_y_reg;
        err_next   = err_reg;
        latch      = 1'b0;
        latch_crc  = crc_reg ^ CRC_INIT;
        latch_pix  = pix_reg;
        latch_line = line_reg;
        latch_err  = 1'b1;
        if (sdl_de) begin
            if (state_reg == WAIT_SOF) begin
                if (is_sof && is_eof) begin
                    latch      = 1'b1;
                    latch_crc  = crc_sof ^ CRC_INIT;
                    latch_pix  = 20'd1;
                    latch_line = 10'd1;
                    latch_err  = 1'b0;
                end else if (is_sof) begin
                    state_next = ACTIVE;
                end
            end else if (is_eof) begin
                latch      = 1'b1;
                latch_crc  = crc_upd ^ CRC_INIT;
                latch_pix  = pix_acc;
                latch_line = line_acc;
                latch_err  = err_acc;
                state_next = WAIT_SOF;
            end else if (is_sof) begin
                // Early SOF: latch the partial frame as errored, then restart on this pixel
                latch = 1'b1;
            end else begin
                crc_next = crc_upd;
                pix_next = pix_acc;
                line_next = line_acc;
                err_next = err_acc;
                if (exp_x_reg == X_LAST) begin
                    exp_x_next = 11'd0;
                    exp_y_next = exp_y_reg + 10'd1;
                end else begin
                    exp_x_next = exp_x_reg + 11'd1;
                end
            end
            if (is_sof && !is_eof) begin
                crc_next   = crc_sof;
                pix_next   = 20'd1;
                line_next  = 10'd1;
                exp_x_next = X_INIT;
                exp_y_next = Y_INIT;
                err_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sim_rst) begin
            state_reg    <= WAIT_SOF;
            crc_reg      <= 32'd0;
            pix_reg      <= 20'd0;
            line_reg     <= 10'd0;
            exp_x_reg    <= 11'd0;
            exp_y_reg    <= 10'd0;
            err_reg      <= 1'b0;
            sig_crc      <= 32'd0;
            sig_pix_cnt  <= 20'd0;
            sig_line_cnt <= 10'd0;
            sig_err      <= 1'b0;
            sig_valid    <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            state_reg <= state_next;
            crc_reg   <= crc_next;
            pix_reg   <= pix_next;
            line_reg  <= line_next;
            exp_x_reg <= exp_x_next;
            exp_y_reg <= exp_y_next;
            err_reg   <= err_next;
            sig_valid <= latch;
            if (latch) begin
                sig_crc      <= latch_crc;
                sig_pix_cnt  <= latch_pix;
                sig_line_cnt <= latch_line;
                sig_err      <= latch_err;
                frame_cnt    <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef FRAME_SIG_CMP_EN
    always_ff @(posedge pixel_clk) begin
        if (sim_rst) begin
            sig_mismatch     <= 1'b0;
            sig_mismatch_any <= 1'b0;
        end else if (latch) begin
            sig_mismatch     <= (latch_crc != exp_crc);
            sig_mismatch_any <= sig_mismatch_any || (latch_crc != exp_crc);
        end
    end
`endif

endmodule

// File: tb/tb_frame_sig_capture.sv
// Scoreboard bench for frame_sig_capture: 3x1 known-CRC instance, scaled 32x24 frame instance, 1x1 corner instance.
module tb_frame_sig_capture;

    localparam int MH = 32;
    localparam int MV = 24;

    typedef struct {
        logic [31:0] crc;
        logic [19:0] pix;
        logic [9:0]  lines;
        logic        err;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    exp_t sq[$];
    exp_t mq[$];
    exp_t se, me;
    logic [15:0] fc_s = 16'd0;
    logic [15:0] fc_m = 16'd0;

    // Small instance (3x1)
    logic [10:0] s_sx = '0;
    logic [9:0]  s_sy = '0;
    logic        s_de = 1'b0;
    logic [7:0]  s_r = '0, s_g = '0, s_b = '0;
    logic [31:0] s_crc;
    logic [19:0] s_pix;
    logic [9:0]  s_lines;
    logic        s_err, s_valid;
    logic [15:0] s_fc;

    // Scaled frame instance
    logic [10:0] m_sx = '0;
    logic [9:0]  m_sy = '0;
    logic        m_de = 1'b0;
    logic [7:0]  m_r = '0, m_g = '0, m_b = '0;
    logic [31:0] m_crc;
    logic [19:0] m_pix;
    logic [9:0]  m_lines;
    logic        m_err, m_valid;
    logic [15:0] m_fc;

    // 1x1 instance
    logic [10:0] t_sx = '0;
    logic [9:0]  t_sy = '0;
    logic        t_de = 1'b0;
    logic [7:0]  t_r = '0, t_g = '0, t_b = '0;
    logic [31:0] t_crc;
    logic [19:0] t_pix;
    logic [9:0]  t_lines;
    logic        t_err, t_valid;
    logic [15:0] t_fc;

`ifdef FRAME_SIG_CMP_EN
    logic [31:0] s_exp_crc = 32'h0;
    logic        s_mm, s_mm_any, m_mm, m_mm_any, t_mm, t_mm_any;
`endif

    frame_sig_capture #(.H_ACTIVE(3), .V_ACTIVE(1)) dut_s (
        .pixel_clk(clk), .sim_rst(rst), .sdl_sx(s_sx), .sdl_sy(s_sy), .sdl_de(s_de),
        .sdl_r(s_r), .sdl_g(s_g), .sdl_b(s_b),
`ifdef FRAME_SIG_CMP_EN
        .exp_crc(s_exp_crc), .sig_mismatch(s_mm), .sig_mismatch_any(s_mm_any),
`endif
        .sig_crc(s_crc), .sig_pix_cnt(s_pix), .sig_line_cnt(s_lines),
        .sig_err(s_err), .sig_valid(s_valid), .frame_cnt(s_fc));

    frame_sig_capture #(.H_ACTIVE(MH), .V_ACTIVE(MV)) dut_m (
        .pixel_clk(clk), .sim_rst(rst), .sdl_sx(m_sx), .sdl_sy(m_sy), .sdl_de(m_de),
        .sdl_r(m_r), .sdl_g(m_g), .sdl_b(m_b),
`ifdef FRAME_SIG_CMP_EN
        .exp_crc(32'h0), .sig_mismatch(m_mm), .sig_mismatch_any(m_mm_any),
`endif
        .sig_crc(m_crc), .sig_pix_cnt(m_pix), .sig_line_cnt(m_lines),
        .sig_err(m_err), .sig_valid(m_valid), .frame_cnt(m_fc));

    frame_sig_capture #(.H_ACTIVE(1), .V_ACTIVE(1)) dut_t (
        .pixel_clk(clk), .sim_rst(rst), .sdl_sx(t_sx), .sdl_sy(t_sy), .sdl_de(t_de),
        .sdl_r(t_r), .sdl_g(t_g), .sdl_b(t_b),
`ifdef FRAME_SIG_CMP_EN
        .exp_crc(32'h0), .sig_mismatch(t_mm), .sig_mismatch_any(t_mm_any),
`endif
        .sig_crc(t_crc), .sig_pix_cnt(t_pix), .sig_line_cnt(t_lines),
        .sig_err(t_err), .sig_valid(t_valid), .frame_cnt(t_fc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference CRC-32/IEEE (reflected), one pixel = bytes r, g, b
    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] r, g, b);
        logic [31:0] c;
        logic [7:0]  bytes [3];
        c = c_in;
        bytes[0] = r; bytes[1] = g; bytes[2] = b;
        for (int i = 0; i < 3; i++) begin
            c = c ^ {24'd0, bytes[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sp(input int x, input int y, input logic [7:0] r, g, b);
        s_sx = 11'(x); s_sy = 10'(y); s_r = r; s_g = g; s_b = b; s_de = 1'b1;
        @(posedge clk); #1;
        s_de = 1'b0;
    endtask

    task automatic push_s(input logic [31:0] crc, input int pix, input int lines, input logic err);
        fc_s = fc_s + 16'd1;
        sq.push_back('{crc, 20'(pix), 10'(lines), err, fc_s});
    endtask

    task automatic push_m(input logic [31:0] crc, input int pix, input int lines, input logic err);
        fc_m = fc_m + 16'd1;
        mq.push_back('{crc, 20'(pix), 10'(lines), err, fc_m});
    endtask

    // Frame model for the scaled instance, built from the stimulus itself
    logic [31:0] md_crc;
    int          md_pix, md_lines;
    logic        md_err;
    logic        md_open = 1'b0;

    task automatic m_frame(input int skip_x, input int start_y, input int stop_y, input logic [7:0] seed);
        logic [7:0] r, g, b;
        for (int y = start_y; y < MV && y != stop_y; y++) begin
            for (int x = 0; x < MH; x++) begin
                if (!(y == 0 && x == skip_x)) begin
                    r = 8'(x) ^ seed; g = 8'(y); b = 8'(x + y) + seed;
                    if (x == 0 && y == 0) begin
                        if (md_open) push_m(md_crc ^ 32'hFFFFFFFF, md_pix, md_lines, 1'b1);
                        md_crc = 32'hFFFFFFFF; md_pix = 0; md_lines = 0;
                        md_err = (skip_x >= 0); md_open = 1'b1;
                    end
                    md_crc = ref_crc(md_crc, r, g, b);
                    md_pix++;
                    if (x == 0) md_lines++;
                    if (md_open && x == MH - 1 && y == MV - 1) begin
                        push_m(md_crc ^ 32'hFFFFFFFF, md_pix, md_lines, md_err);
                        md_open = 1'b0;
                    end
                    m_sx = 11'(x); m_sy = 10'(y); m_r = r; m_g = g; m_b = b; m_de = 1'b1;
                    @(posedge clk); #1;
                    m_de = 1'b0;
                end
            end
            idle(4);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (sq.size() != 0 || mq.size() != 0); i++) idle(1);
        check("sq_drain", sq.size(), 0);
        check("mq_drain", mq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && s_valid) begin
            if (sq.size() == 0) check("s_unexpected_valid", 1, 0);
            else begin
                se = sq.pop_front();
                $display("[%0t] s frame: crc=%h pix=%0d lines=%0d err=%0d fc=%0d",
                         $time, s_crc, s_pix, s_lines, s_err, s_fc);
                check("s_crc", s_crc, se.crc);
                check("s_pix", 32'(s_pix), 32'(se.pix));
                check("s_lines", 32'(s_lines), 32'(se.lines));
                check("s_err", 32'(s_err), 32'(se.err));
                check("s_fc", 32'(s_fc), 32'(se.fc));
            end
        end
        if (!rst && m_valid) begin
            if (mq.size() == 0) check("m_unexpected_valid", 1, 0);
            else begin
                me = mq.pop_front();
                $display("[%0t] m frame: crc=%h pix=%0d lines=%0d err=%0d fc=%0d",
                         $time, m_crc, m_pix, m_lines, m_err, m_fc);
                check("m_crc", m_crc, me.crc);
                check("m_pix", 32'(m_pix), 32'(me.pix));
                check("m_lines", 32'(m_lines), 32'(me.lines));
                check("m_err", 32'(m_err), 32'(me.err));
                check("m_fc", 32'(m_fc), 32'(me.fc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c;
        idle(3);
        check("rst_s_crc", s_crc, 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_m_fc", 32'(m_fc), 32'h0);
        rst = 1'b0;
        idle(2);
        check("idle_s_pix", 32'(s_pix), 32'h0);

        // Known CRC: "123456789"
        $display("step: known CRC on 3x1");
        sp(0, 0, 8'h31, 8'h32, 8'h33);
        sp(1, 0, 8'h34, 8'h35, 8'h36);
        push_s(32'hCBF43926, 3, 1, 1'b0);
        sp(2, 0, 8'h37, 8'h38, 8'h39);
        check("s_valid_latency", 32'(s_valid), 32'h1);
        idle(1);
        check("s_valid_one_cycle", 32'(s_valid), 32'h0);
        drain();
        check("s_crc_hold", s_crc, 32'hCBF43926);

`ifdef FRAME_SIG_CMP_EN
        $display("step: expected-CRC compare");
        s_exp_crc = 32'hCBF43926;
        sp(0, 0, 8'h31, 8'h32, 8'h33); sp(1, 0, 8'h34, 8'h35, 8'h36);
        push_s(32'hCBF43926, 3, 1, 1'b0);
        sp(2, 0, 8'h37, 8'h38, 8'h39);
        drain();
        check("s_mm_match", 32'(s_mm), 32'h0);
        check("s_mm_any_clear", 32'(s_mm_any), 32'h0);
        s_exp_crc = 32'h0;
        sp(0, 0, 8'h31, 8'h32, 8'h33); sp(1, 0, 8'h34, 8'h35, 8'h36);
        push_s(32'hCBF43926, 3, 1, 1'b0);
        sp(2, 0, 8'h37, 8'h38, 8'h39);
        drain();
        check("s_mm_miss", 32'(s_mm), 32'h1);
        s_exp_crc = 32'hCBF43926;
        sp(0, 0, 8'h31, 8'h32, 8'h33); sp(1, 0, 8'h34, 8'h35, 8'h36);
        push_s(32'hCBF43926, 3, 1, 1'b0);
        sp(2, 0, 8'h37, 8'h38, 8'h39);
        drain();
        check("s_mm_rematch", 32'(s_mm), 32'h0);
        check("s_mm_any_sticky", 32'(s_mm_any), 32'h1);
`endif

        // Out-of-range coordinate mid-frame, de gaps in between
        $display("step: out-of-range pixel on 3x1");
        c = ref_crc(32'hFFFFFFFF, 8'h10, 8'h20, 8'h30);
        c = ref_crc(c, 8'hAA, 8'h55, 8'h0F);
        c = ref_crc(c, 8'h01, 8'h02, 8'h03);
        sp(0, 0, 8'h10, 8'h20, 8'h30); idle(2);
        sp(5, 0, 8'hAA, 8'h55, 8'h0F); idle(3);
        push_s(c ^ 32'hFFFFFFFF, 3, 1, 1'b1);
        sp(2, 0, 8'h01, 8'h02, 8'h03);
        drain();

        // Early SOF: partial frame latched with err, restart on same pixel
        $display("step: early SOF on 3x1");
        c = ref_crc(32'hFFFFFFFF, 8'h11, 8'h22, 8'h33);
        c = ref_crc(c, 8'h44, 8'h55, 8'h66);
        sp(0, 0, 8'h11, 8'h22, 8'h33);
        push_s(c ^ 32'hFFFFFFFF, 2, 1, 1'b1);
        sp(1, 0, 8'h44, 8'h55, 8'h66);
        sp(0, 0, 8'h77, 8'h88, 8'h99);
        c = ref_crc(32'hFFFFFFFF, 8'h77, 8'h88, 8'h99);
        c = ref_crc(c, 8'hDE, 8'hAD, 8'hBE);
        c = ref_crc(c, 8'hEF, 8'h00, 8'hFF);
        sp(1, 0, 8'hDE, 8'hAD, 8'hBE);
        push_s(c ^ 32'hFFFFFFFF, 3, 1, 1'b0);
        sp(2, 0, 8'hEF, 8'h00, 8'hFF);
        drain();

        // 1x1: a single pixel is both SOF and EOF
        $display("step: 1x1 frame");
        t_sx = 11'd0; t_sy = 10'd0; t_r = 8'h31; t_g = 8'h32; t_b = 8'h33; t_de = 1'b1;
        @(posedge clk); #1;
        t_de = 1'b0;
        c = ref_crc(32'hFFFFFFFF, 8'h31, 8'h32, 8'h33) ^ 32'hFFFFFFFF;
        check("t_valid", 32'(t_valid), 32'h1);
        check("t_crc", t_crc, c);
        check("t_pix", 32'(t_pix), 32'h1);
        check("t_lines", 32'(t_lines), 32'h1);
        check("t_err", 32'(t_err), 32'h0);
        check("t_fc", 32'(t_fc), 32'h1);
        idle(1);
        check("t_valid_drop", 32'(t_valid), 32'h0);

        // Scaled full frames
        $display("step: two identical full frames");
        m_frame(-1, 0, -1, 8'h00);
        drain();
        m_frame(-1, 0, -1, 8'h00);
        drain();
        check("m_fc_two", 32'(m_fc), 32'h2);

        $display("step: skipped pixel");
        m_frame(6, 0, -1, 8'h5A);
        drain();

        $display("step: early SOF at half frame");
        m_frame(-1, 0, MV / 2, 8'h33);
        m_frame(-1, 0, -1, 8'hC3);
        drain();

        $display("step: reset mid-frame");
        m_frame(-1, 0, 10, 8'h77);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        md_open = 1'b0; fc_m = 16'd0; fc_s = 16'd0;
        check("rst_m_crc", m_crc, 32'h0);
        check("rst_m_pix", 32'(m_pix), 32'h0);
        check("rst_m_lines", 32'(m_lines), 32'h0);
        check("rst_m_err", 32'(m_err), 32'h0);
        check("rst_m_fc_mid", 32'(m_fc), 32'h0);
        check("rst_s_fc_mid", 32'(s_fc), 32'h0);
        m_frame(-1, 10, -1, 8'h77);
        idle(5);
        check("m_no_valid_after_rst", 32'(m_fc), 32'h0);
        m_frame(-1, 0, -1, 8'h21);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sig_capture.md
Name: frame_sig_capture

Overview:
- Downstream consumer of the simulation top's registered SDL pixel stream: sdl_sx, sdl_sy, sdl_de and 8-bit sdl_r/g/b.
- Computes a per-frame CRC-32 signature over all active pixels, plus pixel and line counts and a geometry-error flag.
- Latches the results once per frame so regression benches can compare rendered pingpong frames without dumping images.
- Runs in the pixel clock domain next to the SDL output registers.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 600, active lines per frame.

Ports:
- pixel_clk  input  1  pixel clock.
- sim_rst  input  1  synchronous, active-high reset.
- sdl_sx  input  11  horizontal coordinate.
- sdl_sy  input  10  vertical coordinate.
- sdl_de  input  1  display enable; pixel is valid when high.
- sdl_r  input  8  red.
- sdl_g  input  8  green.
- sdl_b  input  8  blue.
- sig_crc  output  32  CRC-32 of the last completed frame.
- sig_pix_cnt  output  20  active pixels in the last completed frame.
- sig_line_cnt  output  10  lines started in the last completed frame.
- sig_err  output  1  geometry error seen in the last completed frame.
- sig_valid  output  1  one-cycle pulse when the sig_* outputs update.
- frame_cnt  output  16  number of completed frames, wraps 0xFFFF to 0.

Behaviour:
- One clock: pixel_clk. Reset sim_rst is synchronous and active-high. On reset, all outputs are 0 and the FSM enters WAIT_SOF.
- A pixel is consumed on any rising edge where sdl_de=1.
- SOF: a consumed pixel with sdl_sx=0 and sdl_sy=0.
- EOF: a consumed pixel with sdl_sx=H_ACTIVE-1 and sdl_sy=V_ACTIVE-1.
- CRC algorithm: CRC-32/IEEE, reflected, poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. Each pixel feeds three bytes in the order r, g, b, all within one cycle (combinational 24-bit update).
- FSM states:
  - WAIT_SOF: ignores pixels until SOF. On SOF, goes to ACTIVE and initialises CRC, pix count and line count with that pixel: pix=1, lines=1, exp_x=1, exp_y=0, err=0.
  - ACTIVE, per consumed pixel:
    - If sdl_sx!=exp_x or sdl_sy!=exp_y, set the frame err bit (sticky for the frame).
    - Update the CRC and increment pix.
    - Advance exp_x. At H_ACTIVE-1 it wraps to 0, exp_y increments, and lines increments when the next line's first pixel arrives.
  - ACTIVE, on EOF (including that pixel's contribution):
    - Latch sig_crc (final-XORed), sig_pix_cnt, sig_line_cnt and sig_err.
    - Pulse sig_valid; increment frame_cnt.
    - Return to WAIT_SOF.
- Latency: outputs and sig_valid are visible in the cycle after the EOF pixel is presented. sig_valid is high for exactly one cycle.
- Early SOF while ACTIVE (sx=0, sy=0, not EOF):
  - Latch the partial frame with sig_err=1, pulse sig_valid, increment frame_cnt.
  - In the same cycle, restart accumulation with this pixel as a new SOF, staying in ACTIVE.
- With H_ACTIVE=1 and V_ACTIVE=1 a pixel is both SOF and EOF: latch immediately from WAIT_SOF.
- Coordinates outside the active range while sdl_de=1 in ACTIVE set err. They are still CRC'd and counted.
- sdl_de=0 cycles do not alter state.
- Counters saturate: sig_pix_cnt at 0xFFFFF, line count at 0x3FF. Saturation also sets err.
- Reset mid-frame discards the partial frame. No sig_valid is issued for it.

Optional Feature:
- Macro: FRAME_SIG_CMP_EN.
- Defined:
  - Adds input exp_crc[31:0] and outputs sig_mismatch (1 bit) and sig_mismatch_any (1 bit).
  - sig_mismatch updates with sig_valid: 1 if the final CRC != exp_crc, else 0. It holds until the next latch.
  - sig_mismatch_any is sticky, set with sig_mismatch and cleared only by sim_rst.
  - Both reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Known CRC: H_ACTIVE=3, V_ACTIVE=1; pixels (0x31,0x32,0x33), (0x34,0x35,0x36), (0x37,0x38,0x39) with de=1 -> next cycle sig_crc=0xCBF43926, pix=3, lines=1, err=0, sig_valid for one cycle, frame_cnt=1.
- Default 800x600 full frame, all pixels zero, de gaps of 224 cycles between lines -> pix=480000, lines=600, err=0, one sig_valid; the second identical frame gives the same CRC and frame_cnt=2.
- Skipped pixel (sx jumps 5->7 on line 0) -> err=1 at EOF, pix=479999.
- Early SOF at line 300 -> sig_valid with err=1 and pix=240000; the next full frame completes with err=0.
- sim_rst asserted mid-frame for 1 cycle -> all outputs 0, no sig_valid until the next full SOF..EOF.
- With FRAME_SIG_CMP_EN: exp_crc=0xCBF43926 on the 3x1 test -> sig_mismatch=0; exp_crc=0 -> sig_mismatch=1 and sig_mismatch_any stays 1 after a subsequent matching frame.
